// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with a small byte FIFO, overflow flag and framing-error pulse.
// rxd is double-synchronised; each byte is pushed one cycle after its stop bit is accepted.
module uart_rx_fifo #(
  parameter int CLKS_PER_BIT = 868,
  parameter int DEPTH        = 16,
  parameter int AW           = 4
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          rxd,
  output logic [7:0]    rx_data,
  output logic          rx_valid,
  input  logic          rx_ready,
  output logic [AW:0]   level,
  output logic          frame_err,
  output logic          overflow,
  input  logic          clear_ovf,
  output logic          busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);
  localparam logic [AW:0] FULL_LVL  = (AW + 1)'(DEPTH);

  logic         rxd_m, rxd_s;
  state_t       state, state_d;
  logic [15:0]  cnt, cnt_d;
  logic [2:0]   bit_idx, bit_d;
  logic [7:0]   shreg, shreg_d;
  logic         push_q, push_d;
  logic         ferr_d;

  // Two-flop synchroniser; idle level is high so a reset never looks like a start bit.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rxd_m <= 1'b1;
      rxd_s <= 1'b1;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      rxd_m <= rxd;
      rxd_s <= rxd_m;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= S_IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      push_q    <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      bit_idx   <= bit_d;
      shreg     <= shreg_d;
      push_q    <= push_d;
      frame_err <= ferr_d;
    end
  end

  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    state_d = state;
    cnt_d   = cnt;
    bit_d   = bit_idx;
    shreg_d = shreg;
    push_d  = 1'b0;
    ferr_d  = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (!rxd_s) begin
          state_d = S_START;
          cnt_d   = '0;
        end
      end
      S_START: begin
        if (cnt == HALF_LAST) begin
          cnt_d = '0;
          if (!rxd_s) begin
            state_d = S_DATA;
            bit_d   = '0;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt + 16'd1;
        end
      end
      S_DATA: begin
        if (cnt == BIT_LAST) begin
          cnt_d            = '0;
          shreg_d[bit_idx] = rxd_s;
          bit_d            = bit_idx + 3'd1;
          if (bit_idx == 3'd7) state_d = S_STOP;
        end else begin
          cnt_d = cnt + 16'd1;
        end
      end
      S_STOP: begin
        if (cnt == BIT_LAST) begin
          cnt_d = '0;
          if (rxd_s) begin
            push_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = S_BREAK;
          end
        end else begin
          cnt_d = cnt + 16'd1;
        end
      end
      S_BREAK: begin
        if (rxd_s) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy = (state != S_IDLE);

  logic [7:0]    mem [DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr;
  logic [AW-1:0] rd_next_idx;
  logic          full, pop, wr_en, ovf_set;

  assign level       = wr_ptr - rd_ptr;
  assign rx_valid    = (level != '0);
  assign full        = (level == FULL_LVL);
  assign pop         = rx_valid & rx_ready;
  assign wr_en       = push_q & (~full | pop);
  assign ovf_set     = push_q & full & ~pop;
  assign rd_next_idx = rd_ptr[AW-1:0] + AW'(1);

  // NOTE: the byte storage has no reset; only pointers and flags define FIFO contents.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= shreg;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      rx_data  <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + (AW + 1)'(1);
      if (pop)   rd_ptr <= rd_ptr + (AW + 1)'(1);
      // The next head comes from RAM unless the popped entry was the last one,
      // in which case a simultaneous push supplies it directly.
      if (pop) begin
        if (level > (AW + 1)'(1)) rx_data <= mem[rd_next_idx];
        else if (wr_en)           rx_data <= shreg;
      end else if (wr_en && !rx_valid) begin
        rx_data <= shreg;
      end
      if (ovf_set)        overflow <= 1'b1;
      else if (clear_ovf) overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: serial byte driver, scoreboard queue checked on every pop.
module tb_uart_rx_fifo;

  localparam int CPB   = 16;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic          clk = 1'b0;
  logic          resetn;
  logic          rxd;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          rx_ready;
  logic [AW:0]   level;
  logic          frame_err;
  logic          overflow;
  logic          clear_ovf;
  logic          busy;

  int            n_tests = 0;
  int            n_fail  = 0;
  int            cyc     = 0;
  int            n_ferr  = 0;
  int            t_start, t_valid, f0;
  logic [7:0]    sb_exp;
  logic [7:0]    exp_q[$];

  uart_rx_fifo #(
    .CLKS_PER_BIT(CPB),
    .DEPTH       (DEPTH),
    .AW          (AW)
  ) dut (
    .clk      (clk),
    .resetn   (resetn),
    .rxd      (rxd),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .level    (level),
    .frame_err(frame_err),
    .overflow (overflow),
    .clear_ovf(clear_ovf),
    .busy     (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (resetn === 1'b1 && frame_err === 1'b1) n_ferr++;
  end

  // Scoreboard: every pop must match the oldest byte still expected.
  always @(negedge clk) begin
    if (resetn === 1'b1 && rx_valid === 1'b1 && rx_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("sb_extra_byte", exp_q.size(), 1);
      end else begin
        sb_exp = exp_q.pop_front();
        check("sb_rx_data", rx_data, sb_exp);
      end
    end
  end

  task automatic drive_bit(input logic v);
    rxd = v;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stop_bit, input bit keep);
    if (keep) exp_q.push_back(b);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop_bit);
  endtask

  task automatic drain();
    rx_ready = 1'b1;
    for (int i = 0; i < 4 * DEPTH; i++) begin
      if (level == '0) break;
      @(posedge clk);
      #1;
    end
    rx_ready = 1'b0;
    check("drain_level", level, 0);
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    resetn    = 1'b0;
    rxd       = 1'b1;
    rx_ready  = 1'b0;
    clear_ovf = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", rx_valid, 0);
    check("rst_level", level, 0);
    check("rst_data", rx_data, 8'h00);
    check("rst_ovf", overflow, 0);
    check("rst_ferr", frame_err, 0);
    check("rst_busy", busy, 0);
    resetn = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    // Single byte with exact first-valid latency.
    f0 = n_ferr;
    fork
      send_byte(8'hA5, 1'b1, 1'b1);
      begin
        t_start = cyc + 1;
        t_valid = -1;
        for (int i = 0; i < 400; i++) begin
          @(negedge clk);
          if (rx_valid) begin
            t_valid = cyc;
            break;
          end
        end
      end
    join
    check("t1_latency", t_valid, t_start + 155);
    check("t1_data", rx_data, 8'hA5);
    check("t1_level", level, 1);
    check("t1_no_ferr", n_ferr - f0, 0);
    rx_ready = 1'b1;
    @(posedge clk);
    #1;
    rx_ready = 1'b0;
    check("t1_valid_after_pop", rx_valid, 0);
    check("t1_level_after_pop", level, 0);

    // Short low glitch is rejected.
    f0 = n_ferr;
    rxd = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("t2_busy_high", busy, 1);
    rxd = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("t2_busy_low", busy, 0);
    check("t2_level", level, 0);
    check("t2_no_ferr", n_ferr - f0, 0);

    // Bad stop bit followed by a held-low line, then a good byte.
    f0 = n_ferr;
    send_byte(8'h3C, 1'b0, 1'b0);
    repeat (40) @(posedge clk);
    #1;
    drive_bit(1'b1);
    drive_bit(1'b1);
    check("t3_ferr_pulses", n_ferr - f0, 1);
    check("t3_level", level, 0);
    send_byte(8'h81, 1'b1, 1'b1);
    check("t3_data", rx_data, 8'h81);
    check("t3_level_after", level, 1);
    drain();

    // Overflow: 17th byte dropped, sticky flag, clear.
    for (int i = 0; i < 17; i++) send_byte(8'(i), 1'b1, (i < 16));
    check("t4_level_full", level, 16);
    check("t4_ovf_set", overflow, 1);
    drain();
    check("t4_sb_empty", exp_q.size(), 0);
    check("t4_ovf_sticky", overflow, 1);
    clear_ovf = 1'b1;
    @(posedge clk);
    #1;
    clear_ovf = 1'b0;
    check("t4_ovf_clear", overflow, 0);

    // Push into a full FIFO in the same cycle as a pop is accepted.
    for (int i = 0; i < 16; i++) send_byte(8'h20 + 8'(i), 1'b1, 1'b1);
    check("t5_level_full", level, 16);
    fork
      send_byte(8'h55, 1'b1, 1'b1);
      begin
        repeat (155) @(posedge clk);
        #1;
        rx_ready = 1'b1;
        @(posedge clk);
        #1;
        rx_ready = 1'b0;
      end
    join
    check("t5_level", level, 16);
    check("t5_ovf", overflow, 0);
    drain();
    check("t5_sb_empty", exp_q.size(), 0);

    // Reset during bit 4 abandons the frame.
    fork
      send_byte(8'hF0, 1'b1, 1'b0);
      begin
        repeat (5 * CPB + 8) @(posedge clk);
        #1;
        check("t6_busy_before", busy, 1);
        resetn = 1'b0;
        @(posedge clk);
        #1;
        resetn = 1'b1;
        check("t6_busy", busy, 0);
        check("t6_level", level, 0);
      end
    join
    check("t6_no_byte", rx_valid, 0);
    send_byte(8'h12, 1'b1, 1'b1);
    check("t6_data", rx_data, 8'h12);
    check("t6_level_after", level, 1);
    drain();
    check("t6_sb_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
